// File: rtl/line_refill_ctrl.sv
// Cache miss-refill engine: fetches a 4-word block over a req/gnt/rvalid memory port, returns the critical word early, emits a one-cycle line fill.
// Optional build macro CWF_EN selects critical-word-first fetch order; undefined fetches words 0,1,2,3.
module line_refill_ctrl #(
    parameter int TAG_W   = 3,
    parameter int INDEX_W = 10,
    parameter int WORD_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [TAG_W+INDEX_W+1:0]   req_addr,
    output logic                       req_ready,
    output logic                       mem_req,
    output logic [TAG_W+INDEX_W+1:0]   mem_addr,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [WORD_W-1:0]          mem_rdata,
    output logic                       crit_valid,
    output logic [WORD_W-1:0]          crit_data,
    output logic                       fill_valid,
    output logic [TAG_W-1:0]           fill_tag,
    output logic [INDEX_W-1:0]         fill_index,
    output logic [4*WORD_W-1:0]        fill_data,
    output logic [31:0]                refill_count,
    output logic                       proto_err,
    output logic [1:0]                 state_dbg
);

    // Handshakes: a miss transfers when req_valid && req_ready on a rising edge;
    // mem_req stays high with a stable mem_addr until the edge where mem_gnt is
    // sampled high; each grant is answered by exactly one mem_rvalid beat in WAIT.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic   [TAG_W-1:0]             tag_q;
    logic   [INDEX_W-1:0]           index_q;
    logic   [1:0]                   offset_q;
    logic   [1:0]                   beat_q;
    logic   [3:0][WORD_W-1:0]       line_q;
    logic                           crit_valid_q;
    logic   [WORD_W-1:0]            crit_data_q;
    logic   [31:0]                  refill_count_q;
    logic                           proto_err_q;

    logic   [1:0]                   word_sel;
    logic                           accept;
    logic                           capture;

`ifdef CWF_EN
    // Start at the requested word and wrap modulo the line length.
    assign word_sel = offset_q + beat_q;
`else
    assign word_sel = beat_q;
`endif

    assign accept  = (state_q == IDLE) && req_valid;
    assign capture = (state_q == WAIT) && mem_rvalid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = REQ;
            REQ:     if (mem_gnt)   state_d = WAIT;
            WAIT:    if (mem_rvalid) state_d = (beat_q == 2'd3) ? DONE : REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tag_q          <= '0;
            index_q        <= '0;
            offset_q       <= '0;
            beat_q         <= '0;
            line_q         <= '0;
            crit_valid_q   <= 1'b0;
            crit_data_q    <= '0;
            refill_count_q <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            crit_valid_q <= 1'b0;
            if (accept) begin
                tag_q    <= req_addr[TAG_W+INDEX_W+1:INDEX_W+2];
                index_q  <= req_addr[INDEX_W+1:2];
                offset_q <= req_addr[1:0];
                beat_q   <= 2'd0;
            end
            if (capture) begin
                line_q[word_sel] <= mem_rdata;
                if (word_sel == offset_q) begin
                    crit_valid_q <= 1'b1;
                    crit_data_q  <= mem_rdata;
                end
                if (beat_q != 2'd3) beat_q <= beat_q + 2'd1;
            end
            if (state_q == DONE) refill_count_q <= refill_count_q + 32'd1;
            // Returned data is only legal while a granted beat is outstanding.
            if (mem_rvalid && (state_q != WAIT)) proto_err_q <= 1'b1;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign mem_req      = (state_q == REQ);
    assign mem_addr     = (state_q == REQ) ? {tag_q, index_q, word_sel} : '0;
    assign crit_valid   = crit_valid_q;
    assign crit_data    = crit_data_q;
    assign fill_valid   = (state_q == DONE);
    assign fill_tag     = fill_valid ? tag_q   : '0;
    assign fill_index   = fill_valid ? index_q : '0;
    assign fill_data    = fill_valid ? line_q  : '0;
    assign refill_count = refill_count_q;
    assign proto_err    = proto_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Bench for line_refill_ctrl: directed misses against a behavioural memory, with queued expectations checked by a monitor.
module tb_line_refill_ctrl;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic [14:0]   req_addr;
    logic          req_ready;
    logic          mem_req;
    logic [14:0]   mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          fill_valid;
    logic [2:0]    fill_tag;
    logic [9:0]    fill_index;
    logic [127:0]  fill_data;
    logic [31:0]   refill_count;
    logic          proto_err;
    logic [1:0]    state_dbg;

    line_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_index(fill_index),
        .fill_data(fill_data), .refill_count(refill_count),
        .proto_err(proto_err), .state_dbg(state_dbg)
    );

`ifdef CWF_EN
    localparam int CRIT_T1 = 3;
`else
    localparam int CRIT_T1 = 9;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int fill_cnt = 0;
    int accept_cnt = 0;

    logic [14:0]  exp_addr_q[$];
    logic [31:0]  exp_crit_q[$];
    logic [140:0] exp_fill_q[$];

    // memory model controls
    logic [31:0] data_base = 32'hA0;
    bit          mem_en = 1'b1;
    int          mem_beats = 0;
    int          slow_beat = -1;
    int          slow_gnt = 0;
    int          rv_dly = 1;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [140:0] act, input logic [140:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [14:0] a);
        logic [1:0]   off;
        logic [1:0]   ws;
        logic [127:0] line;
        off = a[1:0];
        for (int b = 0; b < 4; b++) begin
`ifdef CWF_EN
            ws = off + b[1:0];
`else
            ws = b[1:0];
`endif
            exp_addr_q.push_back({a[14:2], ws});
            line[32*b +: 32] = data_base + 32'(b);
        end
        exp_crit_q.push_back(data_base + 32'(off));
        exp_fill_q.push_back({a[14:2], line});
    endtask

    task automatic run_req(input logic [14:0] a, output int fill_cyc, output int crit_cyc,
                           output bit busy_ok, output logic ready_after);
        int guard;
        fill_cyc = -1;
        crit_cyc = -1;
        busy_ok  = 1'b1;
        mem_beats = 0;
        push_req(a);
        @(negedge clk);
        req_addr  = a;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (crit_valid && crit_cyc < 0) crit_cyc = k;
            if (fill_valid) begin
                fill_cyc = k;
                break;
            end
            if (req_ready) busy_ok = 1'b0;
        end
        @(negedge clk);
        ready_after = req_ready;
    endtask

    // ---------------- memory responder ----------------
    initial begin
        logic [14:0] cap_addr;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            while (mem_en && mem_req) begin
                cap_addr = mem_addr;
                repeat ((mem_beats == slow_beat) ? slow_gnt : 0) @(negedge clk);
                mem_gnt = 1'b1;
                mem_beats++;
                @(negedge clk);
                mem_gnt = 1'b0;
                repeat (rv_dly - 1) @(negedge clk);
                if (mem_en) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = data_base + 32'(cap_addr[1:0]);
                end
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) continue;
            if (req_valid && req_ready) accept_cnt++;
            check("ready_while_busy", 141'(req_ready && (mem_req || fill_valid || crit_valid)), 141'(0));
            if (mem_req) begin
                if (exp_addr_q.size() == 0) begin
                    check("mem_req_unexpected", 141'(mem_req), 141'(0));
                end else begin
                    check("mem_addr", 141'(mem_addr), 141'(exp_addr_q[0]));
                    if (mem_gnt) void'(exp_addr_q.pop_front());
                end
            end
            if (crit_valid) begin
                if (exp_crit_q.size() == 0) check("crit_unexpected", 141'(crit_valid), 141'(0));
                else check("crit_data", 141'(crit_data), 141'(exp_crit_q.pop_front()));
            end
            if (fill_valid) begin
                fill_cnt++;
                if (exp_fill_q.size() == 0) check("fill_unexpected", 141'(fill_valid), 141'(0));
                else check("fill_line", {fill_tag, fill_index, fill_data}, exp_fill_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   fc, cc, guard, f0, a0;
        bit   bok, found;
        logic rdy;
        logic [14:0] addrs [3];

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 141'(state_dbg), 141'(0));
        check("rst_req_ready", 141'(req_ready), 141'(1));
        check("rst_mem_req", 141'(mem_req), 141'(0));
        check("rst_mem_addr", 141'(mem_addr), 141'(0));
        check("rst_fill", {fill_valid, fill_tag, fill_index, fill_data[126:0]}, 141'(0));
        check("rst_crit", 141'({crit_valid, crit_data}), 141'(0));
        check("rst_count_err", 141'({refill_count, proto_err}), 141'(0));
        rst_n = 1'b1;

        // minimum-latency refill
        data_base = 32'hA0;
        run_req(15'h1A37, fc, cc, bok, rdy);
        check("t1_fill_cycle", 141'(fc), 141'(9));
        check("t1_crit_cycle", 141'(cc), 141'(CRIT_T1));
        check("t1_busy", 141'(bok), 141'(1));
        check("t1_ready_after", 141'(rdy), 141'(1));
        check("t1_count", 141'(refill_count), 141'(1));

        // slow grant on beat 1, slow data on every beat
        data_base = 32'h1000;
        slow_beat = 1;
        slow_gnt  = 5;
        rv_dly    = 3;
        run_req(15'h0452, fc, cc, bok, rdy);
        slow_beat = -1;
        rv_dly    = 1;
        check("t3_fill_cycle", 141'(fc), 141'(22));
        check("t3_busy", 141'(bok), 141'(1));
        check("t3_ready_after", 141'(rdy), 141'(1));
        check("t3_count", 141'(refill_count), 141'(2));

        // spurious return data while idle
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("t4_proto_err", 141'(proto_err), 141'(1));
        check("t4_state", 141'(state_dbg), 141'(0));
        check("t4_no_fill", 141'(fill_valid), 141'(0));
        data_base = 32'hB00;
        run_req(15'h7FFC, fc, cc, bok, rdy);
        check("t4_fill_cycle", 141'(fc), 141'(9));
        check("t4_count", 141'(refill_count), 141'(3));
        check("t4_err_sticky", 141'(proto_err), 141'(1));

        // reset during WAIT of beat 2
        data_base = 32'h5000;
        rv_dly    = 4;
        mem_beats = 0;
        push_req(15'h2ABF);
        @(negedge clk);
        req_addr  = 15'h2ABF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (state_dbg == 2'd2 && mem_beats == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reach_wait2", 141'(found), 141'(1));
        mem_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_addr_q.delete();
        exp_crit_q.delete();
        exp_fill_q.delete();
        @(negedge clk);
        check("t5_state", 141'(state_dbg), 141'(0));
        check("t5_ready", 141'(req_ready), 141'(1));
        check("t5_outputs", 141'({fill_valid, crit_valid, mem_req}), 141'(0));
        check("t5_count", 141'(refill_count), 141'(0));
        check("t5_proto_err", 141'(proto_err), 141'(0));
        repeat (8) @(negedge clk);
        mem_en = 1'b1;
        rv_dly = 1;

        // three back-to-back requests with req_valid held
        data_base = 32'hC0DE0000;
        addrs[0] = 15'h0001;
        addrs[1] = 15'h4006;
        addrs[2] = 15'h7FFB;
        for (int n = 0; n < 3; n++) push_req(addrs[n]);
        f0 = fill_cnt;
        a0 = accept_cnt;
        @(negedge clk);
        req_addr  = addrs[0];
        req_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            guard = 0;
            while (!req_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            @(posedge clk);
            #1;
            if (n < 2) req_addr = addrs[n+1];
            else req_valid = 1'b0;
            @(negedge clk);
        end
        guard = 0;
        while (fill_cnt < f0 + 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("t6_fills", 141'(fill_cnt - f0), 141'(3));
        check("t6_accepts", 141'(accept_cnt - a0), 141'(3));
        check("t6_count", 141'(refill_count), 141'(3));

        check("end_addr_q_empty", 141'(exp_addr_q.size()), 141'(0));
        check("end_crit_q_empty", 141'(exp_crit_q.size()), 141'(0));
        check("end_fill_q_empty", 141'(exp_fill_q.size()), 141'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
